// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage constants, FSM encoding and the IF/ID entry type.
// No logic of its own; imported by the fetch unit, its IF/ID register and interface.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_KILL  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: pipeline control in, instruction memory request/response, IF/ID out.
// master = fetch unit, slave = surrounding pipeline and instruction memory.
interface instruction_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  modport master (
    input  stall, branch_taken, branch_target, imem_readdata, imem_busywait,
    output imem_addr, imem_read, if_id_pc, if_id_instr, if_id_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_readdata, imem_busywait,
    input  imem_addr, imem_read, if_id_pc, if_id_instr, if_id_valid
  );
endinterface

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load, flush to NOP bubble (PC kept), or hold; one-cycle latency.
// Flush wins over load; holding is the default when neither is asserted.
module if_id_reg
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry.pc    <= RESET_PC;
      entry.instr <= NOP_INSTR;
      valid       <= 1'b0;
    end else if (flush) begin
      entry.instr <= NOP_INSTR;
      valid       <= 1'b0;
    end else if (load) begin
      entry <= load_entry;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, FETCH/HOLD/KILL FSM and one-entry stall buffer feeding IF/ID.
// One instruction per cycle on zero-wait memory; busywait inserts bubbles, stall parks data in HOLD.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  logic [1:0]   state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  kill_addr, kill_addr_nxt;
  fetch_entry_t hold_buf, hold_buf_nxt;
  fetch_entry_t load_entry, id_entry;
  logic         load, flush, done, id_valid;

  assign bus.imem_read = !reset && (state != ST_HOLD);
  assign bus.imem_addr = (state == ST_KILL) ? kill_addr : pc;
  assign done          = bus.imem_read && !bus.imem_busywait;

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    kill_addr_nxt    = kill_addr;
    hold_buf_nxt     = hold_buf;
    load             = 1'b0;
    flush            = 1'b0;
    load_entry.pc    = pc;
    load_entry.instr = bus.imem_readdata;

    if (bus.branch_taken) begin
      pc_nxt = word_align(bus.branch_target);
      flush  = 1'b1;
      case (state)
        ST_FETCH: begin
          // An outstanding request cannot be retracted, so park its address until it drains.
          if (bus.imem_busywait) begin
            kill_addr_nxt = pc;
            state_nxt     = ST_KILL;
          end
        end
        ST_HOLD: state_nxt = ST_FETCH;
        ST_KILL: state_nxt = ST_KILL;
        default: state_nxt = ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (done) begin
            if (!bus.stall) begin
              load   = 1'b1;
              pc_nxt = pc + PC_INC;
            end else begin
              hold_buf_nxt = load_entry;
              state_nxt    = ST_HOLD;
            end
          end else if (!bus.stall) begin
            flush = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!bus.stall) begin
            load       = 1'b1;
            load_entry = hold_buf;
            pc_nxt     = pc + PC_INC;
            state_nxt  = ST_FETCH;
          end
        end
        ST_KILL: begin
          if (!bus.stall) flush = 1'b1;
          if (done) state_nxt = ST_FETCH;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_FETCH;
      pc             <= RESET_PC;
      kill_addr      <= RESET_PC;
      hold_buf.pc    <= RESET_PC;
      hold_buf.instr <= NOP_INSTR;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      kill_addr <= kill_addr_nxt;
      hold_buf  <= hold_buf_nxt;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (reset),
    .load       (load),
    .flush      (flush),
    .load_entry (load_entry),
    .entry      (id_entry),
    .valid      (id_valid)
  );

  assign bus.if_id_pc    = id_entry.pc;
  assign bus.if_id_instr = id_entry.instr;
  assign bus.if_id_valid = id_valid;

endmodule
